// File: rtl/herring_bus_master_if.sv
// Herring system bus bundle: command/response handshake toward the FPGA fabric
// plus the PHI2-timed address/data bus toward RAM, VIA and ACIA.
interface herring_bus_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        phi2;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_data_out;
    logic        bus_data_oe;
    logic [7:0]  bus_data_in;
    logic        busy;

    modport master (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, bus_data_in,
        output cmd_ready, rsp_valid, rsp_rdata, phi2, bus_addr, bus_rw,
               bus_data_out, bus_data_oe, busy
    );

    modport slave (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, bus_data_in,
        input  cmd_ready, rsp_valid, rsp_rdata, phi2, bus_addr, bus_rw,
               bus_data_out, bus_data_oe, busy
    );
endinterface

// File: rtl/herring_bus_master.sv
// 6502-style bus initiator: each accepted command becomes one PHI2 bus cycle,
// address/RW set up in the low phase, data driven or sampled in the high phase.
module herring_bus_master #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic                 i_clk_src,
    input  logic                 i_reset,
    herring_bus_master_if.master bus_if
);
    localparam int unsigned LOW_CYC  = CLK_DIV / 2;
    localparam int unsigned HIGH_CYC = CLK_DIV - LOW_CYC;
    localparam int unsigned CW       = $clog2(CLK_DIV);

    localparam logic [CW-1:0] LOW_LAST  = CW'(LOW_CYC - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOW  = 2'b01,
        ST_HIGH = 2'b10
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_phi2;
    logic          r_oe;
    logic          r_busy;
    logic          r_ready;
    logic          r_rsp_valid;
    logic [7:0]    r_rdata;
    logic [15:0]   r_addr;
    logic          r_rw;
    logic [7:0]    r_wdata;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_load;
    logic          w_sample;
    logic          w_rsp_nxt;

    // Next-state and phase counter; all bus outputs are registered from these.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_sample    = 1'b0;
        w_rsp_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus_if.cmd_valid && r_ready) begin
                    w_state_nxt = ST_LOW;
                    w_cnt_nxt   = CNT_ZERO;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (r_cnt == LOW_LAST) begin
                    w_state_nxt = ST_HIGH;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (r_cnt == HIGH_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_rsp_nxt   = 1'b1;
                    w_sample    = r_rw;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // State, phase counter and registered bus outputs; reset aborts any cycle in flight.
    always_ff @(posedge i_clk_src or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_ZERO;
            r_phi2      <= 1'b0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= 8'h00;
            r_addr      <= 16'h0000;
            r_rw        <= 1'b1;
            r_wdata     <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_phi2      <= (w_state_nxt == ST_HIGH);
            // r_rw is already stable when HIGH is entered, so it gates oe directly.
            r_oe        <= (w_state_nxt == ST_HIGH) && !r_rw;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= w_rsp_nxt;
            if (w_load) begin
                r_addr  <= bus_if.cmd_addr;
                r_rw    <= bus_if.cmd_rw;
                r_wdata <= bus_if.cmd_wdata;
            end
            if (w_sample) begin
                r_rdata <= bus_if.bus_data_in;
            end
        end
    end

    assign bus_if.cmd_ready    = r_ready;
    assign bus_if.rsp_valid    = r_rsp_valid;
    assign bus_if.rsp_rdata    = r_rdata;
    assign bus_if.phi2         = r_phi2;
    assign bus_if.bus_addr     = r_addr;
    assign bus_if.bus_rw       = r_rw;
    assign bus_if.bus_data_out = r_wdata;
    assign bus_if.bus_data_oe  = r_oe;
    assign bus_if.busy         = r_busy;
endmodule

// File: tb/tb_herring_bus_master.sv
// Randomized bench for herring_bus_master at CLK_DIV=50 and CLK_DIV=5, checked
// cycle by cycle against a count-since-accept model of the bus cycle.
module tb_herring_bus_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    localparam int NCYC = 3000;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DIV   = (g == 0) ? 50 : 5;
        localparam int LOWC  = DIV / 2;
        localparam int HIGHC = DIV - LOWC;
        localparam int RK    = (HIGHC < 10) ? HIGHC : 10;

        logic rst;
        bit   fin;
        herring_bus_master_if hif ();
        herring_bus_master #(.CLK_DIV(DIV)) u_dut (
            .i_clk_src (clk),
            .i_reset   (rst),
            .bus_if    (hif)
        );

        initial begin : stim
            int          j;
            logic        m_rw;
            logic [15:0] m_addr;
            logic [7:0]  m_wdata;
            logic [7:0]  m_rdata;
            bit          rst_done;
            bit          e_phi2;
            bit          e_busy;
            string       p;

            p = (g == 0) ? "div50" : "div5";
            fin = 1'b0;
            rst = 1'b1;
            hif.cmd_valid   = 1'b0;
            hif.cmd_rw      = 1'b1;
            hif.cmd_addr    = 16'h0000;
            hif.cmd_wdata   = 8'h00;
            hif.bus_data_in = 8'h00;
            j = 0; m_rw = 1'b1; m_addr = 16'h0000; m_wdata = 8'h00; m_rdata = 8'h00;
            rst_done = 1'b0;

            repeat (3) @(negedge clk);
            check_val({p, ".rst_phi2"},  32'(hif.phi2),         32'd0);
            check_val({p, ".rst_oe"},    32'(hif.bus_data_oe),  32'd0);
            check_val({p, ".rst_rw"},    32'(hif.bus_rw),       32'd1);
            check_val({p, ".rst_addr"},  32'(hif.bus_addr),     32'd0);
            check_val({p, ".rst_dout"},  32'(hif.bus_data_out), 32'd0);
            check_val({p, ".rst_rsp"},   32'(hif.rsp_valid),    32'd0);
            check_val({p, ".rst_rdata"}, 32'(hif.rsp_rdata),    32'd0);
            rst = 1'b0;

            for (int cyc = 0; cyc < NCYC; cyc++) begin
                @(negedge clk);
                // j = cycles since acceptance; 0 means idle with no response pending
                e_phi2 = (j > LOWC) && (j <= DIV);
                e_busy = (j >= 1) && (j <= DIV);
                check_val({p, ".phi2"},  32'(hif.phi2),         32'(e_phi2));
                check_val({p, ".oe"},    32'(hif.bus_data_oe),  32'(e_phi2 && !m_rw));
                check_val({p, ".busy"},  32'(hif.busy),         32'(e_busy));
                check_val({p, ".ready"}, 32'(hif.cmd_ready),    32'(!e_busy));
                check_val({p, ".rsp"},   32'(hif.rsp_valid),    32'(j == DIV + 1));
                check_val({p, ".addr"},  32'(hif.bus_addr),     32'(m_addr));
                check_val({p, ".rw"},    32'(hif.bus_rw),       32'(m_rw));
                check_val({p, ".dout"},  32'(hif.bus_data_out), 32'(m_wdata));
                check_val({p, ".rdata"}, 32'(hif.rsp_rdata),    32'(m_rdata));

                if (!rst_done && cyc > NCYC / 3 && j == LOWC + RK && !m_rw) begin
                    rst = 1'b1;
                    #1;
                    check_val({p, ".abort_phi2"}, 32'(hif.phi2),        32'd0);
                    check_val({p, ".abort_oe"},   32'(hif.bus_data_oe), 32'd0);
                    check_val({p, ".abort_rw"},   32'(hif.bus_rw),      32'd1);
                    check_val({p, ".abort_addr"}, 32'(hif.bus_addr),    32'd0);
                    j = 0; m_rw = 1'b1; m_addr = 16'h0000; m_wdata = 8'h00; m_rdata = 8'h00;
                    hif.cmd_valid = 1'b0;
                    @(negedge clk);
                    check_val({p, ".abort_rsp"}, 32'(hif.rsp_valid), 32'd0);
                    rst = 1'b0;
                    rst_done = 1'b1;
                end else begin
                    // alternate windows of held cmd_valid with sparse random requests
                    if (((cyc / 200) % 2) == 1)
                        hif.cmd_valid = 1'b1;
                    else
                        hif.cmd_valid = ($urandom_range(0, 3) == 0);
                    hif.cmd_rw      = 1'($urandom_range(0, 1));
                    hif.cmd_addr    = 16'($urandom);
                    hif.cmd_wdata   = 8'($urandom);
                    hif.bus_data_in = 8'($urandom);

                    if (j == DIV && m_rw) m_rdata = hif.bus_data_in;
                    if (j == 0 || j == DIV + 1) begin
                        if (hif.cmd_valid) begin
                            j       = 1;
                            m_rw    = hif.cmd_rw;
                            m_addr  = hif.cmd_addr;
                            m_wdata = hif.cmd_wdata;
                        end else begin
                            j = 0;
                        end
                    end else begin
                        j = j + 1;
                    end
                end
            end
            check_val({p, ".reset_hit"}, 32'(rst_done), 32'd1);
            fin = 1'b1;
        end
    end

    initial begin : supervisor
        for (int t = 0; t < 20000 && !(g_dut[0].fin && g_dut[1].fin); t++) @(posedge clk);
        check_val("completion", 32'(g_dut[0].fin && g_dut[1].fin), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
